itcm_icb_slave: RTL and testbench
=================================

ITCM_ICB_SLAVE -- requirements
Module: itcm_icb_slave

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the SRAM word and data bus width in bits (multiple of 8, at least 32).
REQ-002 SHALL have parameter RAM_DEPTH, default 14, meaning the number of word-address bits (2^RAM_DEPTH words).
REQ-003 SHALL have parameter OUTS, default 2, meaning the maximum number of outstanding commands, 1..8.
REQ-004 SHALL have parameter CANCEL_MODE, default 0, meaning 0 = return cancelled responses with rsp_cancel=1 and 1 = drop them silently.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 icb_cmd_valid  in  1  command request.
REQ-008 icb_cmd_ready  out  1  command accept.
REQ-009 icb_cmd_read  in  1  1 = read, 0 = write.
REQ-010 icb_cmd_addr  in  `HiCore_ADDR_SIZE  byte address.
REQ-011 icb_cmd_wdata  in  DW  write data.
REQ-012 icb_cmd_wmask  in  DW/8  byte write enables.
REQ-013 icb_rsp_valid  out  1  response available.
REQ-014 icb_rsp_ready  in  1  response accept.
REQ-015 icb_rsp_rdata  out  DW  read data (0 for writes and errors).
REQ-016 icb_rsp_err  out  1  address error.
REQ-017 icb_rsp_cancel  out  1  response belongs to a squashed stream.
REQ-018 flush, branch  in  1 each  pipeline redirect; either one is a "redirect".

Function
REQ-019 A command handshake (valid&&ready) SHALL issue the SRAM access in the same cycle; with no older responses pending, icb_rsp_valid SHALL rise the next cycle (1-cycle latency).
REQ-020 Responses SHALL return strictly in command order, through a pipeline stage S1 that bypasses to the outputs when the response FIFO is empty and otherwise pushes into it.
REQ-021 An outstanding counter SHALL increment on command handshake and decrement on response handshake (net 0 when both occur); icb_cmd_ready = (counter < OUTS).
REQ-022 The response FIFO SHALL have OUTS entries and SHALL never overflow, given REQ-021; it wraps pointers modulo OUTS.
REQ-023 A write SHALL update only the bytes whose wmask bit is set; SRAM contents are not reset.
REQ-024 The word index SHALL be addr[RAM_DEPTH+1:2]; a nonzero addr[1:0], or any nonzero address bit above RAM_DEPTH+1, SHALL give rsp_err=1 and rdata=0 without any SRAM access.
REQ-025 Mode 0: a redirect in cycle t SHALL set the cancel bit of every response whose command was accepted before t (in S1 and the FIFO); those responses still handshake, with rsp_cancel=1.
REQ-026 Mode 1: a redirect SHALL empty the FIFO, invalidate S1, and set the counter to 1 if a command is accepted in the same cycle, else 0; a response handshake in that cycle is discarded.
REQ-027 A command accepted in the same cycle as a redirect SHALL be treated as new-stream, i.e. never cancelled.
REQ-028 Back-to-back redirects SHALL be idempotent; rdata SHALL hold stable while rsp_valid is high and rsp_ready is low.

Reset
REQ-029 While rst_n is low: counter=0, FIFO empty, S1 invalid, rsp_valid=0, rsp_err=0, rsp_cancel=0, rdata=0, and cmd_ready=1 as soon as rst_n rises.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight responses, with no response emitted afterwards for them.

Structure
REQ-031 `HiCore_ADDR_SIZE and the CANCEL_MODE encodings SHALL come from the shared HiCore defines include.
REQ-032 The response FIFO (data, err, cancel per entry; parameterised width and depth) SHALL be the sub-module icb_rsp_fifo; the SRAM array is inferred inline.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 with wmask 4'b1111, then read 0x10 -> rsp_valid one cycle after accept, rdata=0xDEADBEEF, err=0.
REQ-034 OUTS=2, rsp_ready=0, three read commands -> the first two are accepted and cmd_ready=0 on the third; releasing rsp_ready returns responses in order.
REQ-035 Mode 0: two reads pending, then flush together with a new read to 0x20 -> two responses with cancel=1, followed by 0x20 data with cancel=0.
REQ-036 Mode 1: same stimulus -> only the 0x20 response appears, and the counter equals 1 after the flush.
REQ-037 Read of address 0x0001_0000 (RAM_DEPTH=14) and of 0x2 -> both give err=1, rdata=0.
REQ-038 rst_n pulsed low with 2 responses pending -> no responses afterwards, and cmd_ready=1 once rst_n rises.

Source files
------------

// File: rtl/itcm_icb_slave_pkg.sv
// Shared HiCore system values and small helpers for the ITCM ICB slave.
package itcm_icb_slave_pkg;

  // HiCore system byte-address width
  localparam int HICORE_ADDR_SIZE = 32;

  // HiCore cancel-mode encodings: flag cancelled responses, or drop them
  typedef enum logic [0:0] {
    CANCEL_FLAG = 1'b0,
    CANCEL_DROP = 1'b1
  } cancel_mode_e;

  // Outstanding counter width, enough for 0..8
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cnt, logic inc, logic dec);
    return cnt + CNT_W'(inc) - CNT_W'(dec);
  endfunction

endpackage

// File: rtl/itcm_icb_slave_if.sv
// ICB command/response bundle between a core and the ITCM.
interface itcm_icb_slave_if
  import itcm_icb_slave_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = HICORE_ADDR_SIZE
);
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic            icb_cmd_read;
  logic [AW-1:0]   icb_cmd_addr;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic [DW-1:0]   icb_rsp_rdata;
  logic            icb_rsp_err;
  logic            icb_rsp_cancel;

  modport master (
    output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, icb_rsp_cancel
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err, icb_rsp_cancel
  );
endinterface

// File: rtl/icb_rsp_fifo.sv
// In-order response queue: data, err and cancel per entry, with a bulk
// cancel (mark every entry) and a flush (discard every entry).
module icb_rsp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          cancel_all_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          push_err_i,
  input  logic          push_cancel_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [DW-1:0] head_data_o,
  output logic          head_err_o,
  output logic          head_cancel_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] cancel_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  assign rd_ptr_d = pop_i ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  assign cnt_d    = cnt_q + CW'(push_i) - CW'(pop_i);

  assign empty_o       = (cnt_q == '0);
  assign head_data_o   = data_q[rd_ptr_q];
  assign head_err_o    = err_q[rd_ptr_q];
  assign head_cancel_o = cancel_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; the pushed entry's own cancel bit overrides the bulk mark
  always_ff @(posedge clk) begin
    if (cancel_all_i) cancel_q <= '1;
    if (push_i && !flush_i) begin
      data_q[wr_ptr_q]   <= push_data_i;
      err_q[wr_ptr_q]    <= push_err_i;
      cancel_q[wr_ptr_q] <= push_cancel_i;
    end
  end

endmodule

// File: rtl/itcm_icb_slave.sv
// ITCM behind an ICB slave port: single-cycle SRAM access, in-order
// responses via stage S1 plus a response FIFO, redirect cancel handling.
module itcm_icb_slave
  import itcm_icb_slave_pkg::*;
#(
  parameter int DW          = 32,
  parameter int RAM_DEPTH   = 14,
  parameter int OUTS        = 2,
  parameter int CANCEL_MODE = 0
) (
  input logic             clk,
  input logic             rst_n,
  itcm_icb_slave_if.slave icb,
  input logic             flush,
  input logic             branch
);
  localparam logic DROP = (CANCEL_MODE == int'(CANCEL_DROP));

  logic                 cmd_hs, rsp_hs, redirect, mark_all, drop_all;
  logic                 addr_err, ram_access;
  logic [RAM_DEPTH-1:0] word_idx;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 s1_vld_q, s1_rd_q, s1_err_q;
  logic [DW-1:0]        ram_q, s1_data;
  logic [DW-1:0]        mem_q [2**RAM_DEPTH];
  logic                 fifo_empty, fifo_push, fifo_pop;
  logic [DW-1:0]        head_data;
  logic                 head_err, head_cancel;

  assign redirect = flush | branch;
  assign mark_all = redirect & ~DROP;
  assign drop_all = redirect & DROP;

  assign cmd_hs = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign rsp_hs = icb.icb_rsp_valid & icb.icb_rsp_ready;

  assign word_idx   = icb.icb_cmd_addr[RAM_DEPTH+1:2];
  assign addr_err   = (icb.icb_cmd_addr[1:0] != 2'b00) || ((icb.icb_cmd_addr >> (RAM_DEPTH + 2)) != '0);
  assign ram_access = cmd_hs & ~addr_err;

  assign icb.icb_cmd_ready = (cnt_q < CNT_W'(OUTS));

  // S1 lives for one cycle; it reaches the port directly when nothing older
  // is queued, otherwise it is parked in the FIFO behind older responses.
  assign s1_data   = (s1_vld_q && s1_rd_q) ? ram_q : '0;
  assign fifo_pop  = ~fifo_empty & rsp_hs & ~drop_all;
  assign fifo_push = s1_vld_q & ~(fifo_empty & rsp_hs) & ~drop_all;

  assign icb.icb_rsp_valid  = fifo_empty ? s1_vld_q : 1'b1;
  assign icb.icb_rsp_rdata  = fifo_empty ? s1_data : head_data;
  assign icb.icb_rsp_err    = fifo_empty ? (s1_vld_q & s1_err_q) : head_err;
  assign icb.icb_rsp_cancel = fifo_empty ? 1'b0 : head_cancel;

  // In drop mode a redirect restarts the count from this cycle's new command
  assign cnt_d = drop_all ? CNT_W'(cmd_hs) : cnt_next(cnt_q, cmd_hs, rsp_hs);

  // SRAM array: byte-masked write, registered read, contents never reset
  always_ff @(posedge clk) begin
    if (ram_access) begin
      if (icb.icb_cmd_read) begin
        ram_q <= mem_q[word_idx];
      end else begin
        for (int b = 0; b < DW/8; b++) begin
          if (icb.icb_cmd_wmask[b]) mem_q[word_idx][8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  // S1 stage and outstanding counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_rd_q  <= 1'b0;
      s1_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= cmd_hs;
      s1_rd_q  <= cmd_hs & icb.icb_cmd_read & ~addr_err;
      s1_err_q <= cmd_hs & addr_err;
      cnt_q    <= cnt_d;
    end
  end

  icb_rsp_fifo #(
    .DW    (DW),
    .DEPTH (OUTS)
  ) u_rsp_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (drop_all),
    .cancel_all_i  (mark_all),
    .push_i        (fifo_push),
    .push_data_i   (s1_data),
    .push_err_i    (s1_err_q),
    .push_cancel_i (mark_all),
    .pop_i         (fifo_pop),
    .empty_o       (fifo_empty),
    .head_data_o   (head_data),
    .head_err_o    (head_err),
    .head_cancel_o (head_cancel)
  );

endmodule

// File: tb/tb_itcm_icb_slave.sv
// Bench for itcm_icb_slave: directed table, multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_itcm_icb_slave;
  import itcm_icb_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic fl0, br0, fla, bra;

  always #5 clk = ~clk;

  itcm_icb_slave_if #(.DW(32)) if0 ();
  itcm_icb_slave_if #(.DW(32)) ifa ();
  itcm_icb_slave_if #(.DW(32)) ifb ();

  itcm_icb_slave #(.DW(32), .RAM_DEPTH(14), .OUTS(2), .CANCEL_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .icb(if0), .flush(fl0), .branch(br0));
  itcm_icb_slave #(.DW(32), .RAM_DEPTH(14), .OUTS(4), .CANCEL_MODE(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .icb(ifa), .flush(fla), .branch(bra));
  itcm_icb_slave #(.DW(32), .RAM_DEPTH(14), .OUTS(4), .CANCEL_MODE(1)) dut_m1 (
    .clk(clk), .rst_n(rst_n), .icb(ifb), .flush(fla), .branch(bra));

  typedef struct { logic [31:0] data; logic err; logic cancel; logic known; } rsp_t;
  typedef struct { logic [31:0] data; logic cancel; } got_t;
  typedef struct {
    logic rd; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wmask;
    logic [31:0] exp_rdata; logic exp_err;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  rsp_t        q0[$];
  logic [31:0] mm[int];
  got_t        ra[$], rb[$];
  vec_t        tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: word-addressed memory; error if misaligned or beyond 64 KiB
  function automatic rsp_t model_access(logic rd, logic [31:0] a, logic [31:0] wd, logic [3:0] wm);
    rsp_t r;
    int w;
    logic [31:0] old;
    r.data = 32'd0; r.cancel = 1'b0; r.known = 1'b1;
    r.err = ((a % 4) != 0) || (a >= 32'h0001_0000);
    if (r.err) return r;
    w = int'(a / 4);
    if (rd) begin
      if (mm.exists(w)) r.data = mm[w];
      else r.known = 1'b0;
    end else if (wm == 4'hF) begin
      mm[w] = wd;
    end else if (mm.exists(w)) begin
      old = mm[w];
      for (int b = 0; b < 4; b++) if (wm[b]) old[8*b +: 8] = wd[8*b +: 8];
      mm[w] = old;
    end
    return r;
  endfunction

  task automatic idle0(input logic rr);
    if0.icb_cmd_valid = 1'b0; if0.icb_cmd_read = 1'b0; if0.icb_cmd_addr = 32'd0;
    if0.icb_cmd_wdata = 32'd0; if0.icb_cmd_wmask = 4'd0; if0.icb_rsp_ready = rr;
    fl0 = 1'b0; br0 = 1'b0;
  endtask

  // One cycle on dut0 (called at negedge): drive, compare with model, step model
  task automatic cyc0(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input logic rr, input logic fl, input logic br);
    rsp_t e;
    logic cmd_hs, rsp_hs;
    if0.icb_cmd_valid = v; if0.icb_cmd_read = rd; if0.icb_cmd_addr = a;
    if0.icb_cmd_wdata = wd; if0.icb_cmd_wmask = wm; if0.icb_rsp_ready = rr;
    fl0 = fl; br0 = br;
    #1;
    chk("cmd_ready", 32'(if0.icb_cmd_ready), 32'(q0.size() < 2));
    chk("rsp_valid", 32'(if0.icb_rsp_valid), 32'(q0.size() != 0));
    if (q0.size() != 0) begin
      chk("rsp_err", 32'(if0.icb_rsp_err), 32'(q0[0].err));
      chk("rsp_cancel", 32'(if0.icb_rsp_cancel), 32'(q0[0].cancel));
      if (q0[0].known) chk("rsp_rdata", if0.icb_rsp_rdata, q0[0].data);
    end
    cmd_hs = v && (q0.size() < 2);
    rsp_hs = rr && (q0.size() != 0);
    if (rsp_hs) void'(q0.pop_front());
    if (fl || br) for (int i = 0; i < q0.size(); i++) q0[i].cancel = 1'b1;
    if (cmd_hs) begin
      e = model_access(rd, a, wd, wm);
      q0.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic set_ab(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic rr, input logic fl);
    ifa.icb_cmd_valid = v; ifa.icb_cmd_read = rd; ifa.icb_cmd_addr = a;
    ifa.icb_cmd_wdata = wd; ifa.icb_cmd_wmask = 4'hF; ifa.icb_rsp_ready = rr;
    ifb.icb_cmd_valid = v; ifb.icb_cmd_read = rd; ifb.icb_cmd_addr = a;
    ifb.icb_cmd_wdata = wd; ifb.icb_cmd_wmask = 4'hF; ifb.icb_rsp_ready = rr;
    fla = fl; bra = 1'b0;
  endtask

  // One cycle on the mode-0/mode-1 pair; records every response handshake
  task automatic cyc_ab(input logic v, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic rr, input logic fl);
    got_t g;
    set_ab(v, rd, a, wd, rr, fl);
    #1;
    chk("m0_cmd_ready", 32'(ifa.icb_cmd_ready), 32'd1);
    chk("m1_cmd_ready", 32'(ifb.icb_cmd_ready), 32'd1);
    if (ifa.icb_rsp_valid && rr) begin g.data = ifa.icb_rsp_rdata; g.cancel = ifa.icb_rsp_cancel; ra.push_back(g); end
    if (ifb.icb_rsp_valid && rr) begin g.data = ifb.icb_rsp_rdata; g.cancel = ifb.icb_rsp_cancel; rb.push_back(g); end
    @(negedge clk);
  endtask

  initial begin
    int nv;
    tbl[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0014, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b0, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 32'h0000_0014, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0018, 32'h5566_7788, 4'hF, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0018, 32'h0000_0000, 4'h8, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0018, 32'h0,         4'h0, 32'h0066_7788, 1'b0};
    tbl[8]  = '{1'b1, 32'h0001_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_0002, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    tbl[11] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0011, 32'h0,         4'hF, 32'h0000_0000, 1'b1};
    tbl[13] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};

    rst_n = 1'b0;
    idle0(1'b0);
    set_ab(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(if0.icb_rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(if0.icb_rsp_err), 32'd0);
    chk("reset_rsp_cancel", 32'(if0.icb_rsp_cancel), 32'd0);
    chk("reset_rsp_rdata", if0.icb_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_cmd_ready", 32'(if0.icb_cmd_ready), 32'd1);
    @(negedge clk);

    // Directed table: one command, response expected on the following cycle
    for (int i = 0; i < 14; i++) begin
      cyc0(1'b1, tbl[i].rd, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, 1'b1, 1'b0, 1'b0);
      idle0(1'b1);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(if0.icb_rsp_valid), 32'd1);
      chk($sformatf("tbl%0d_rdata", i), if0.icb_rsp_rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(if0.icb_rsp_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_cancel", i), 32'(if0.icb_rsp_cancel), 32'd0);
      cyc0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    end

    // Back-pressure: two reads fill OUTS=2, third is held off until drained
    cyc0(1'b1, 1'b1, 32'h10, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 1'b1, 32'h14, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    if0.icb_cmd_addr = 32'h18;
    #1;
    chk("full_cmd_ready", 32'(if0.icb_cmd_ready), 32'd0);
    chk("full_head_rdata", if0.icb_rsp_rdata, 32'hDEAD_BEEF);
    cyc0(1'b1, 1'b1, 32'h18, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("stall_hold_rdata", if0.icb_rsp_rdata, 32'hDEAD_BEEF);
    cyc0(1'b1, 1'b1, 32'h18, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_second_rdata", if0.icb_rsp_rdata, 32'h11BB_33DD);
    cyc0(1'b1, 1'b1, 32'h18, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_third_rdata", if0.icb_rsp_rdata, 32'h0066_7788);
    repeat (3) cyc0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Redirect with two reads pending plus a new read: mode 0 vs mode 1
    cyc_ab(1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1, 1'b0);
    cyc_ab(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    ra.delete(); rb.delete();
    cyc_ab(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    cyc_ab(1'b1, 1'b1, 32'h14, 32'h0, 1'b0, 1'b0);
    cyc_ab(1'b1, 1'b1, 32'h20, 32'h0, 1'b0, 1'b1);
    set_ab(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    chk("m1_cnt_after_flush", 32'(dut_m1.cnt_q), 32'd1);
    @(negedge clk);
    repeat (8) cyc_ab(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("m0_rsp_count", 32'(ra.size()), 32'd3);
    if (ra.size() >= 3) begin
      chk("m0_rsp0_cancel", 32'(ra[0].cancel), 32'd1);
      chk("m0_rsp1_cancel", 32'(ra[1].cancel), 32'd1);
      chk("m0_rsp2_cancel", 32'(ra[2].cancel), 32'd0);
      chk("m0_rsp2_rdata", ra[2].data, 32'hCAFE_F00D);
    end
    chk("m1_rsp_count", 32'(rb.size()), 32'd1);
    if (rb.size() >= 1) begin
      chk("m1_rsp0_cancel", 32'(rb[0].cancel), 32'd0);
      chk("m1_rsp0_rdata", rb[0].data, 32'hCAFE_F00D);
    end

    // Randomized traffic on dut0 against the queue model
    for (int w = 0; w < 8; w++)
      cyc0(1'b1, 1'b0, 32'h100 + 32'(4*w), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 15);
      if (sel == 0) a = 32'h0001_0100;
      else if (sel == 1) a = 32'h0000_0102;
      else a = 32'h100 + 32'(4 * $urandom_range(0, 7));
      cyc0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    end
    repeat (4) cyc0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);

    // Reset with two responses pending: nothing may come out afterwards
    cyc0(1'b1, 1'b1, 32'h100, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc0(1'b1, 1'b1, 32'h104, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle0(1'b0);
    #1;
    chk("prereset_rsp_valid", 32'(if0.icb_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(if0.icb_rsp_valid), 32'd0);
    chk("midreset_rsp_rdata", if0.icb_rsp_rdata, 32'd0);
    chk("midreset_rsp_err", 32'(if0.icb_rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    #1;
    chk("postreset_cmd_ready", 32'(if0.icb_cmd_ready), 32'd1);
    @(negedge clk);
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      if (if0.icb_rsp_valid) nv++;
      cyc0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    end
    chk("postreset_rsp_count", 32'(nv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
